// File: rtl/pipelined_cla_adder_if.sv
// Handshake/bus bundle for pipelined_cla_adder: operand beat in, result beat out.
// Latency: none (wires only).
// Backpressure: carries in_ready/out_ready; the adder drives in_ready from out_ready.
// Signals: in_valid/in_ready/a/b/cin/sub (operand side), out_valid/out_ready/sum/cout
// (result side), ovf/zero only when CLA_FLAGS_EN is defined.
// Modports: master = producer/consumer side, slave = the adder.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_FLAGS_EN
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
`else
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, STAGE_BITS result bits per stage.
// Latency: WIDTH/STAGE_BITS cycles from accept to out_valid; one beat per cycle.
// Backpressure: global stall, in_ready = !out_valid | out_ready; the whole pipe freezes.
// Ports: clk, rst (synchronous, active high); bus (slave modport) carries the operand
// beat (in_valid/in_ready/a/b/cin/sub) and result beat (out_valid/out_ready/sum/cout).
// Option macro CLA_FLAGS_EN: adds registered ovf (signed overflow) and zero flags.
module pipelined_cla_adder #(
  parameter int WIDTH      = 32,
  parameter int STAGE_BITS = 8
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int L      = WIDTH / STAGE_BITS;
  localparam int GROUPS = STAGE_BITS / 4;

  // Operands are shifted right as slices are consumed so the live slice is always
  // at bit 0; result slices enter at the top and end up in place after L stages.
  typedef struct packed {
    logic             vld;
    logic             cy;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t st  [L];
  stage_t nxt [L];

  logic                  advance;
  logic                  out_valid_q;
  logic [WIDTH-1:0]      sum_q;
  logic                  cout_q;
  logic [STAGE_BITS-1:0] p;
  logic [STAGE_BITS-1:0] g;
  logic [STAGE_BITS-1:0] s;
  logic [STAGE_BITS:0]   c;
`ifdef CLA_FLAGS_EN
  logic                  top_cy;
  logic                  ovf_q;
  logic                  zero_q;
`endif

  assign advance      = !out_valid_q | bus.out_ready;
  assign bus.in_ready = advance;

  // Carries into every bit of a slice (c[STAGE_BITS] is the slice carry-out).
  // Full lookahead inside each 4-bit group; group G/P chain groups in the same cycle.
  function automatic logic [STAGE_BITS:0] slice_carries(
    input logic [STAGE_BITS-1:0] pv,
    input logic [STAGE_BITS-1:0] gv,
    input logic                  c0
  );
    logic [STAGE_BITS:0] cv;
    logic [3:0]          pp;
    logic [3:0]          gg;
    logic                ci;
    cv    = '0;
    cv[0] = c0;
    for (int j = 0; j < GROUPS; j++) begin
      pp = pv[4*j +: 4];
      gg = gv[4*j +: 4];
      ci = cv[4*j];
      cv[4*j+1] = gg[0] | (pp[0] & ci);
      cv[4*j+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
      cv[4*j+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                | (pp[2] & pp[1] & pp[0] & ci);
      cv[4*j+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & ci);
    end
    return cv;
  endfunction

  always_comb begin
    p = '0;
    g = '0;
    s = '0;
    c = '0;
`ifdef CLA_FLAGS_EN
    top_cy = 1'b0;
`endif
    for (int k = 0; k < L; k++) begin
      p = st[k].a[STAGE_BITS-1:0] ^ st[k].b[STAGE_BITS-1:0];
      g = st[k].a[STAGE_BITS-1:0] & st[k].b[STAGE_BITS-1:0];
      c = slice_carries(p, g, st[k].cy);
      s = p ^ c[STAGE_BITS-1:0];
      nxt[k].vld = st[k].vld;
      nxt[k].cy  = c[STAGE_BITS];
      nxt[k].a   = st[k].a >> STAGE_BITS;
      nxt[k].b   = st[k].b >> STAGE_BITS;
      nxt[k].sum = (st[k].sum >> STAGE_BITS) | (WIDTH'(s) << (WIDTH - STAGE_BITS));
`ifdef CLA_FLAGS_EN
      // carry into the MSB comes from the last slice only
      if (k == L - 1) top_cy = c[STAGE_BITS-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < L; k++) st[k] <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
`ifdef CLA_FLAGS_EN
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
`endif
    end else if (advance) begin
      // in_ready == advance here, so in_valid alone marks an accepted beat
      st[0].vld <= bus.in_valid;
      st[0].cy  <= bus.sub | bus.cin;
      st[0].a   <= bus.a;
      st[0].b   <= bus.sub ? ~bus.b : bus.b;
      st[0].sum <= '0;
      for (int k = 1; k < L; k++) st[k] <= nxt[k-1];
      out_valid_q <= nxt[L-1].vld;
      sum_q       <= nxt[L-1].sum;
      cout_q      <= nxt[L-1].cy;
`ifdef CLA_FLAGS_EN
      ovf_q       <= nxt[L-1].cy ^ top_cy;
      zero_q      <= (nxt[L-1].sum == '0);
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef CLA_FLAGS_EN
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
`endif
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder, WIDTH=32, STAGE_BITS=8 (four stages).
// Table of hand-computed vectors plus model-generated random vectors, streamed
// with steady, held and random out_ready; latency and mid-flight reset by hand.
module tb_pipelined_cla_adder;
  localparam int W  = 32;
  localparam int SB = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vec [256];
  int   n_vec = 0;

  pipelined_cla_adder_if #(.WIDTH(W)) bus ();

  pipelined_cla_adder #(.WIDTH(W), .STAGE_BITS(SB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input logic [W-1:0] sum, input logic cout,
                         input logic ovf, input logic zero);
    vec[n_vec].a = a;     vec[n_vec].b = b;
    vec[n_vec].cin = cin; vec[n_vec].sub = sub;
    vec[n_vec].sum = sum; vec[n_vec].cout = cout;
    vec[n_vec].ovf = ovf; vec[n_vec].zero = zero;
    n_vec++;
  endtask

  // Reference: two's-complement sum on a 33-bit accumulator; overflow from operand signs.
  task automatic add_rand(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ov;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    add_vec(a, b, cin, sub, full[W-1:0], full[W], ov, full[W-1:0] == '0);
  endtask

  task automatic drive(input int idx);
    bus.a   = vec[idx].a;
    bus.b   = vec[idx].b;
    bus.cin = vec[idx].cin;
    bus.sub = vec[idx].sub;
  endtask

  task automatic compare_res(input string tag, input int idx);
    check({tag, "_sum"},  bus.sum, vec[idx].sum);
    check({tag, "_cout"}, W'(bus.cout), W'(vec[idx].cout));
`ifdef CLA_FLAGS_EN
    check({tag, "_ovf"},  W'(bus.ovf),  W'(vec[idx].ovf));
    check({tag, "_zero"}, W'(bus.zero), W'(vec[idx].zero));
`endif
  endtask

  // mode 0: out_ready always 1; 1: out_ready low 5 cycles after first result; 2: random.
  task automatic stream(input string tag, input int first, input int cnt, input int mode);
    int           tx;
    int           rx;
    int           hold;
    bit           hold_done;
    logic [W-1:0] held_sum;
    tx = 0; rx = 0; hold = 0; hold_done = 0; held_sum = '0;
    for (int cyc = 0; cyc < cnt * 4 + 60 && rx < cnt; cyc++) begin
      @(negedge clk);
      bus.in_valid = (tx < cnt);
      if (tx < cnt) drive(first + tx);
      case (mode)
        0: bus.out_ready = 1'b1;
        1: begin
          if (!hold_done && bus.out_valid) begin
            hold = 5; hold_done = 1; held_sum = bus.sum;
          end
          bus.out_ready = (hold == 0);
        end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (hold > 0) begin
        check({tag, "_in_ready_stalled"}, W'(bus.in_ready), W'(1'b0));
        check({tag, "_out_valid_stalled"}, W'(bus.out_valid), W'(1'b1));
        if (hold < 5) check({tag, "_sum_held"}, bus.sum, held_sum);
        hold--;
      end
      if (bus.out_valid && bus.out_ready) begin
        compare_res(tag, first + rx);
        rx++;
      end
      if (bus.in_valid && bus.in_ready) tx++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check({tag, "_delivered"}, W'(rx), W'(cnt));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check({tag, "_no_extra"}, W'(bus.out_valid), W'(1'b0));
    end
  endtask

  // Single beat: out_valid low after edges n..n+3, result after edge n+4.
  task automatic latency_check(input string tag, input int idx);
    @(negedge clk);
    drive(idx);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check({tag, "_early_valid"}, W'(bus.out_valid), W'(1'b0));
    end
    @(negedge clk);
    check({tag, "_valid"}, W'(bus.out_valid), W'(1'b1));
    compare_res(tag, idx);
  endtask

  initial begin
    //          a             b             cin  sub  sum           cout ovf  zero
    add_vec(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    add_vec(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    add_vec(32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    add_vec(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    add_vec(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    add_vec(32'h00000001, 32'h00000002, 1'b1, 1'b0, 32'h00000004, 1'b0, 1'b0, 1'b0);
    add_vec(32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0);
    add_vec(32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0);
    add_vec(32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
    add_vec(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
    add_vec(32'h00FF00FF, 32'h0001FF01, 1'b0, 1'b0, 32'h01010000, 1'b0, 1'b0, 1'b0);
    add_vec(32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    add_vec(32'hDEADBEEF, 32'h21524111, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = (i % 7 == 0) ? ~ra : $urandom;
      add_rand(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", W'(bus.out_valid), W'(1'b0));
    check("reset_sum",       bus.sum,           '0);
    check("reset_cout",      W'(bus.cout),      W'(1'b0));
    check("reset_in_ready",  W'(bus.in_ready),  W'(1'b1));
    @(negedge clk);
    rst = 1'b0;

    latency_check("lat_ripple", 0);
    stream("table", 0, 13, 0);
    stream("hold", 0, 8, 1);

    // Reset with three beats in flight, plus a beat presented during reset.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(i + 3);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    drive(6);
    rst = 1'b1;
    #1;
    check("rst_in_ready", W'(bus.in_ready), W'(1'b1));
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check("rst_flushed", W'(bus.out_valid), W'(1'b0));
    end
    latency_check("lat_after_rst", 10);

    stream("random", 13, n_vec - 13, 2);
    stream("all_rand_ready", 0, 13, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor for the arithmetic datapath. Adds or subtracts two WIDTH-bit operands with a carry-in. Each pipeline stage resolves STAGE_BITS result bits using 4-bit lookahead groups and passes the carry to the next stage in a register. A valid/ready handshake on both sides lets it sit between streaming producers and consumers, with full throughput of one operation per cycle.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of STAGE_BITS.
- STAGE_BITS, 8, bits resolved per pipeline stage; must be a multiple of 4.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a+~b+1 (a−b).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB. In subtract mode, 1 means no borrow.
- ovf  output  1  signed overflow; present only when CLA_FLAGS_EN is defined.
- zero  output  1  sum==0; present only when CLA_FLAGS_EN is defined.

## Operation
- L = WIDTH/STAGE_BITS pipeline stages. Each stage holds a valid bit, the partially computed sum, the carry into its slice, and the not-yet-processed operand slices (skew registers).
- Per slice: p=a^b', g=a&b', where b'=sub?~b:b. Carries inside each 4-bit group use full lookahead. Group P/G terms chain carries across the groups of the slice within the same cycle.
- Stage k computes bits [k·STAGE_BITS +: STAGE_BITS] from the registered carry-in. It registers the carry-out for stage k+1.
- Stage 0 carry-in is sub ? 1 : cin.
- Global stall: advance = !out_valid | out_ready; in_ready = advance.
- When advance=1, all stages shift by one. A beat is accepted when in_valid & in_ready.
- When advance=0, every stage register holds its value.
- Bubbles (valid=0) propagate like data. Output order always equals input order.
- ovf = carry into MSB XOR cout, i.e. the standard signed overflow for the effective operation.
- Arithmetic is modulo 2^WIDTH. Only cout carries the extra bit.

## Timing
- Latency: a beat accepted at edge n appears on out_valid/sum at edge n+L, when there is no stall.
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 freezes the whole pipeline. While frozen, sum, cout and flags hold stable. in_ready is low in the same cycle (combinational from out_ready).
- Output deassertion: out_valid drops only after a handshake, or on reset.
- Reset: on the edge where rst=1, every valid bit, sum, cout, ovf, zero and all skew/carry registers clear to 0. Operations in flight are discarded with no output.
  - in_ready=1 during reset, because out_valid=0, but beats presented while rst=1 are dropped.
- Simultaneous events:
  - Accept and output handshake in the same cycle are both honoured.
  - rst overrides all handshakes.

## Configuration
- CLA_FLAGS_EN defined: ovf and zero ports exist, are pipelined alongside sum, and are valid with out_valid.
- CLA_FLAGS_EN undefined: ovf and zero ports and their logic are removed. All other behaviour and latency are unchanged.

## Test plan
All scenarios use WIDTH=32, STAGE_BITS=8 (L=4), with CLA_FLAGS_EN defined unless noted.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> exactly 4 cycles later sum=0x00000000, cout=1, zero=1, ovf=0.
- Subtract with borrow: a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0. Also a=b=0x12345678, sub=1 -> sum=0, cout=1, zero=1.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, ovf=1, cout=0. Also a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1.
- Backpressure: 8 back-to-back beats, with out_ready held 0 for 5 cycles after the first result appears -> in_ready=0 during the hold, results held stable, all 8 results delivered in order with none lost or duplicated.
- Reset mid-flight: 3 beats accepted, then rst=1 for one cycle -> out_valid=0 on the following cycle and never asserts for those beats; a new beat afterwards completes with latency 4.
- Random: 10k random a/b/cin/sub with random out_ready -> every result matches the 33-bit reference model. Repeat with CLA_FLAGS_EN undefined, and with WIDTH=16, STAGE_BITS=4 (L=4).
